// File: rtl/muldiv_unit_if.sv
// Bundle of the request, MTHI/MTLO and result signals exchanged between the
// EX stage (master) and the iterative multiply/divide unit (slave).
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO pair.
// Operands are reduced to magnitudes on entry, iterated for WIDTH cycles
// (shift-add multiply or restoring divide), then sign-corrected in one
// extra cycle before HI/LO are written.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic         clock,
  input logic         reset,
  muldiv_unit_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic               r_dbz_pulse;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_div;
  logic               r_dbz;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [WIDTH-1:0]   r_raw_a;
  logic [WIDTH-1:0]   r_opb;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_quo;

  logic               w_signed;
  logic               w_is_div;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_trial;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz_pulse;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;

  // Operand magnitudes for signed ops; unsigned ops pass operands through.
  always_comb begin
    w_signed = ~bus.op[0];
    w_is_div = bus.op[1];
    w_abs_a  = bus.a;
    w_abs_b  = bus.b;
    if (w_signed && bus.a[WIDTH-1]) w_abs_a = '0 - bus.a;
    if (w_signed && bus.b[WIDTH-1]) w_abs_b = '0 - bus.b;
  end

  // One iteration step of each algorithm and the sign-corrected results.
  always_comb begin
    // Multiply: add multiplicand into the upper half when the LSB of the
    // shifting multiplier is set; the carry becomes the new top bit.
    w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                + (r_acc[0] ? {1'b0, r_opb} : '0);
    // Divide: bring in the next dividend bit and trial-subtract the divisor.
    w_div_shift = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    w_div_trial = w_div_shift - {1'b0, r_opb};
    w_prod      = r_neg_q ? ('0 - r_acc) : r_acc;
    w_quo       = r_neg_q ? ('0 - r_quo) : r_quo;
    w_rem       = r_neg_r ? ('0 - r_rem[WIDTH-1:0]) : r_rem[WIDTH-1:0];
  end

  // Control FSM, iterative datapath and HI/LO ownership.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dbz_pulse <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_cnt       <= '0;
      r_is_div    <= 1'b0;
      r_dbz       <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_raw_a     <= '0;
      r_opb       <= '0;
      r_acc       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
    end else begin
      r_done      <= 1'b0;
      r_dbz_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.hi_we) r_hi <= bus.wdata;
          if (bus.lo_we) r_lo <= bus.wdata;
          if (bus.start && !bus.flush) begin
            r_state  <= S_CALC;
            r_busy   <= 1'b1;
            r_cnt    <= CNT_W'(WIDTH);
            r_is_div <= w_is_div;
            r_dbz    <= w_is_div && (bus.b == '0);
            r_neg_q  <= w_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_neg_r  <= w_signed && bus.a[WIDTH-1];
            r_raw_a  <= bus.a;
            // Multiply keeps |a| as multiplicand and |b| in the low half of
            // the accumulator; divide keeps |b| as divisor and shifts |a|
            // out of the quotient register.
            r_opb    <= w_is_div ? w_abs_b : w_abs_a;
            r_acc    <= {{WIDTH{1'b0}}, w_abs_b};
            r_rem    <= '0;
            r_quo    <= w_abs_a;
          end
        end
        S_CALC: begin
          if (bus.flush) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            if (r_is_div) begin
              if (!w_div_trial[WIDTH]) begin
                r_rem <= w_div_trial;
                r_quo <= {r_quo[WIDTH-2:0], 1'b1};
              end else begin
                r_rem <= w_div_shift;
                r_quo <= {r_quo[WIDTH-2:0], 1'b0};
              end
            end else begin
              r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
            end
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          if (!bus.flush) begin
            r_done <= 1'b1;
            if (!r_is_div) begin
              r_hi <= w_prod[2*WIDTH-1:WIDTH];
              r_lo <= w_prod[WIDTH-1:0];
            end else if (r_dbz) begin
              r_hi        <= r_raw_a;
              r_lo        <= '1;
              r_dbz_pulse <= 1'b1;
            end else begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (WIDTH=32) with hand-computed results.
module tb_muldiv_unit;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, summary not printed");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and wait (bounded) for busy to drop.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int cycles);
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cycles = 0;
    while (bus.busy && cycles < 100) begin
      cycles++;
      tick();
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick();
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_tests++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b want 0", bus.div_by_zero); end
    n_tests++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", bus.hi); end
    n_tests++; if (bus.lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", bus.lo); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_multu;
    int cyc;
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
    n_tests++; if (cyc !== 33) begin n_fail++; $display("FAIL multu_latency: got %0d want 33", cyc); end
    n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL multu_done: got %b want 1", bus.done); end
    n_tests++; if (bus.hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi: got %h want fffffffe", bus.hi); end
    n_tests++; if (bus.lo !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo: got %h want 00000001", bus.lo); end
    n_tests++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL multu_dbz: got %b want 0", bus.div_by_zero); end
    tick();
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL multu_done_pulse: got %b want 0", bus.done); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    do_op(2'b00, 32'hFFFF_FFF9, 32'h3, cyc);
    n_tests++; if (bus.hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_neg_hi: got %h want ffffffff", bus.hi); end
    n_tests++; if (bus.lo !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_neg_lo: got %h want ffffffeb", bus.lo); end
    n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL mult_neg_done: got %b want 1", bus.done); end
    // Start issued in the done cycle must be accepted.
    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, cyc);
    n_tests++; if (cyc !== 33) begin n_fail++; $display("FAIL b2b_latency: got %0d want 33", cyc); end
    n_tests++; if (bus.hi !== 32'h4000_0000) begin n_fail++; $display("FAIL mult_min_hi: got %h want 40000000", bus.hi); end
    n_tests++; if (bus.lo !== 32'h0) begin n_fail++; $display("FAIL mult_min_lo: got %h want 0", bus.lo); end
  endtask

  task automatic test_divide;
    int cyc;
    do_op(2'b10, 32'hFFFF_FFF9, 32'h2, cyc);
    n_tests++; if (bus.lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_q: got %h want fffffffd", bus.lo); end
    n_tests++; if (bus.hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg_r: got %h want ffffffff", bus.hi); end
    tick();
    do_op(2'b11, 32'd100, 32'd7, cyc);
    n_tests++; if (cyc !== 33) begin n_fail++; $display("FAIL divu_latency: got %0d want 33", cyc); end
    n_tests++; if (bus.lo !== 32'd14) begin n_fail++; $display("FAIL divu_q: got %h want 0000000e", bus.lo); end
    n_tests++; if (bus.hi !== 32'd2) begin n_fail++; $display("FAIL divu_r: got %h want 00000002", bus.hi); end
    tick();
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    n_tests++; if (bus.lo !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_q: got %h want 80000000", bus.lo); end
    n_tests++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL div_ovf_r: got %h want 0", bus.hi); end
    n_tests++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL div_ovf_dbz: got %b want 0", bus.div_by_zero); end
    tick();
  endtask

  task automatic test_div_by_zero;
    int cyc;
    do_op(2'b10, 32'd5, 32'd0, cyc);
    n_tests++; if (cyc !== 33) begin n_fail++; $display("FAIL dbz_latency: got %0d want 33", cyc); end
    n_tests++; if (bus.lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dbz_lo: got %h want ffffffff", bus.lo); end
    n_tests++; if (bus.hi !== 32'd5) begin n_fail++; $display("FAIL dbz_hi: got %h want 00000005", bus.hi); end
    n_tests++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL dbz_done: got %b want 1", bus.done); end
    n_tests++; if (bus.div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dbz_flag: got %b want 1", bus.div_by_zero); end
    tick();
    n_tests++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dbz_pulse: got %b want 0", bus.div_by_zero); end
    do_op(2'b10, 32'hFFFF_FFFB, 32'd0, cyc);
    n_tests++; if (bus.hi !== 32'hFFFF_FFFB) begin n_fail++; $display("FAIL dbz_neg_hi: got %h want fffffffb", bus.hi); end
    n_tests++; if (bus.lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dbz_neg_lo: got %h want ffffffff", bus.lo); end
    n_tests++; if (bus.div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dbz_neg_flag: got %b want 1", bus.div_by_zero); end
    tick();
  endtask

  task automatic test_mt_flush;
    bit seen;
    bus.wdata = 32'h11; bus.hi_we = 1'b1; tick(); bus.hi_we = 1'b0;
    n_tests++; if (bus.hi !== 32'h11) begin n_fail++; $display("FAIL mthi: got %h want 00000011", bus.hi); end
    bus.wdata = 32'h22; bus.lo_we = 1'b1; tick(); bus.lo_we = 1'b0;
    n_tests++; if (bus.lo !== 32'h22) begin n_fail++; $display("FAIL mtlo: got %h want 00000022", bus.lo); end
    bus.op = 2'b01; bus.a = 32'd3; bus.b = 32'd4; bus.start = 1'b1;
    tick();                                   // CALC cycle 1
    bus.start = 1'b0;
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mtf_busy: got %b want 1", bus.busy); end
    tick(); tick();                           // CALC cycle 3
    bus.start = 1'b1; bus.hi_we = 1'b1; bus.wdata = 32'h99; bus.a = 32'd5;
    tick();                                   // CALC cycle 4
    bus.start = 1'b0; bus.hi_we = 1'b0;
    n_tests++; if (bus.hi !== 32'h11) begin n_fail++; $display("FAIL mthi_busy: got %h want 00000011", bus.hi); end
    repeat (6) tick();                        // CALC cycle 10
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", bus.busy); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL flush_done: got %b want 0", bus.done); end
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (bus.done || bus.busy) seen = 1'b1;
    end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_quiet: got activity=%b want 0", seen); end
    n_tests++; if (bus.hi !== 32'h11) begin n_fail++; $display("FAIL flush_hi: got %h want 00000011", bus.hi); end
    n_tests++; if (bus.lo !== 32'h22) begin n_fail++; $display("FAIL flush_lo: got %h want 00000022", bus.lo); end
  endtask

  task automatic test_flush_with_start;
    bus.op = 2'b01; bus.a = 32'd6; bus.b = 32'd7;
    bus.start = 1'b1; bus.flush = 1'b1;
    tick();
    bus.start = 1'b0; bus.flush = 1'b0;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_start_busy: got %b want 0", bus.busy); end
    tick();
  endtask

  task automatic test_flush_fix;
    bus.op = 2'b01; bus.a = 32'd5; bus.b = 32'd5; bus.start = 1'b1;
    tick();                                   // CALC cycle 1
    bus.start = 1'b0;
    repeat (32) tick();                       // cycle 33: FIX
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL fix_busy: got %b want 1", bus.busy); end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL fix_flush_busy: got %b want 0", bus.busy); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL fix_flush_done: got %b want 0", bus.done); end
    n_tests++; if (bus.lo !== 32'h22) begin n_fail++; $display("FAIL fix_flush_lo: got %h want 00000022", bus.lo); end
  endtask

  task automatic test_mt_with_start;
    int cyc;
    bus.wdata = 32'h55; bus.hi_we = 1'b1; bus.lo_we = 1'b1;
    bus.op = 2'b00; bus.a = 32'hFFFF_FFFF; bus.b = 32'd2; bus.start = 1'b1;
    tick();
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.start = 1'b0;
    n_tests++; if (bus.hi !== 32'h55) begin n_fail++; $display("FAIL mt_start_hi: got %h want 00000055", bus.hi); end
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mt_start_busy: got %b want 1", bus.busy); end
    cyc = 0;
    while (bus.busy && cyc < 100) begin cyc++; tick(); end
    n_tests++; if (bus.hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mt_start_res_hi: got %h want ffffffff", bus.hi); end
    n_tests++; if (bus.lo !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mt_start_res_lo: got %h want fffffffe", bus.lo); end
    tick();
  endtask

  task automatic test_async_reset;
    int cyc;
    bus.op = 2'b11; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
    tick();                                   // CALC cycle 1
    bus.start = 1'b0;
    repeat (4) tick();                        // CALC cycle 5
    #2 rst = 1'b1;
    #1;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy: got %b want 0", bus.busy); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL areset_done: got %b want 0", bus.done); end
    n_tests++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL areset_hi: got %h want 0", bus.hi); end
    n_tests++; if (bus.lo !== 32'h0) begin n_fail++; $display("FAIL areset_lo: got %h want 0", bus.lo); end
    tick();
    rst = 1'b0;
    tick();
    do_op(2'b11, 32'd9, 32'd3, cyc);
    n_tests++; if (cyc !== 33) begin n_fail++; $display("FAIL post_reset_latency: got %0d want 33", cyc); end
    n_tests++; if (bus.lo !== 32'd3) begin n_fail++; $display("FAIL post_reset_q: got %h want 00000003", bus.lo); end
    n_tests++; if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL post_reset_r: got %h want 0", bus.hi); end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    test_reset();
    test_multu();
    test_back_to_back();
    test_divide();
    test_div_by_zero();
    test_mt_flush();
    test_flush_with_start();
    test_flush_fix();
    test_mt_with_start();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
